// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer.
// Owns the PC, a single-outstanding request/response handshake to a
// variable-latency instruction memory, the IF/ID pipeline register and a
// one-entry skid buffer that catches a response arriving while decode holds
// IF/ID. Redirects from execute flush IF/ID and retarget the PC; a request
// already in flight when a redirect lands is allowed to complete and its
// response is dropped. A saturating counter records cycles spent waiting on
// memory.
module fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [31:0]     wait_cycles
);

  // Sequencer states. IDLE: nothing outstanding. ISSUE: request on the bus
  // this cycle. WAIT: awaiting a live response. HOLD: response parked in the
  // skid buffer behind a stalled IF/ID. DISCARD: awaiting a response that a
  // redirect has already killed.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [31:0]     WAIT_MAX = 32'hFFFF_FFFF;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;

  // IF/ID pipeline register.
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pcd_q;
  logic [XLEN-1:0] pc4d_q;
  logic            valid_q;

  // Skid buffer: the instruction and the PC it was fetched from.
  logic [XLEN-1:0] skid_instr_q;
  logic [XLEN-1:0] skid_pc_q;

  logic [31:0]     wait_q;

  // Per-cycle decisions produced by the sequencer.
  logic            take_mem;    // IF/ID loads straight from the memory response
  logic            take_skid;   // IF/ID loads from the skid buffer
  logic            skid_fill;   // skid buffer captures the memory response
  logic            ifid_free;   // IF/ID can accept a new instruction this cycle
  logic            waiting;     // a memory wait cycle to be counted

  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  assign pc_plus4  = pc_q + PC_STEP;       // wraps modulo 2^XLEN
  assign ifid_free = !valid_q || !StallD;

  // Sequencer: next state, next PC and the IF/ID / skid load strobes.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    take_mem  = 1'b0;
    take_skid = 1'b0;
    skid_fill = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (PCSrcE) pc_d = PCTargetE;
        if (fetch_en) state_d = S_ISSUE;
      end

      S_ISSUE: begin
        // The request to the old PC still goes out; a redirect here only
        // means its response must be thrown away.
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = S_DISCARD;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = imem_rvalid ? S_ISSUE : S_DISCARD;
        end else if (imem_rvalid) begin
          if (ifid_free) begin
            take_mem = 1'b1;
            pc_d     = pc_plus4;
            state_d  = fetch_en ? S_ISSUE : S_IDLE;
          end else begin
            skid_fill = 1'b1;
            state_d   = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = S_ISSUE;
        end else if (!StallD) begin
          take_skid = 1'b1;
          pc_d      = pc_plus4;
          state_d   = fetch_en ? S_ISSUE : S_IDLE;
        end
      end

      S_DISCARD: begin
        if (PCSrcE) pc_d = PCTargetE;
        if (imem_rvalid) state_d = S_ISSUE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values regardless of statement or block order.
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign load_instr = take_skid ? skid_instr_q : imem_rdata;
  assign load_pc    = take_skid ? skid_pc_q    : pc_q;

  // IF/ID register: flush beats load, load beats stall, otherwise a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pcd_q   <= '0;
      pc4d_q  <= '0;
      valid_q <= 1'b0;
    end else if (PCSrcE) begin
      valid_q <= 1'b0;
    end else if (take_mem || take_skid) begin
      instr_q <= load_instr;
      pcd_q   <= load_pc;
      pc4d_q  <= load_pc + PC_STEP;
      valid_q <= 1'b1;
    end else if (!StallD) begin
      valid_q <= 1'b0;
    end
  end

  // Skid buffer: captures a response that IF/ID cannot yet accept.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the skid entry is cleared on reset so a post-reset IF/ID load can
    // never expose stale contents; HOLD is the only state that reads it.
    if (!rst_n) begin
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else if (skid_fill) begin
      skid_instr_q <= imem_rdata;
      skid_pc_q    <= pc_q;
    end
  end

  assign waiting = ((state_q == S_WAIT) || (state_q == S_DISCARD)) && !imem_rvalid;

  // Memory-wait counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (waiting && (wait_q != WAIT_MAX)) begin
      wait_q <= wait_q + 32'd1;
    end
  end

  assign imem_req    = (state_q == S_ISSUE);
  assign imem_addr   = pc_q;
  assign InstrD      = instr_q;
  assign PCD         = pcd_q;
  assign PCPlus4D    = pc4d_q;
  assign ValidD      = valid_q;
  assign wait_cycles = wait_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic for fetch_ctrl.
// Two instances differ only in RESET_PC; the bench observes one at a time.
// A memory responder answers each request after a chosen latency with
// rdata = addr | 32'hA000_0000. A transaction-level model (outstanding /
// killed / parked flags) predicts every output each cycle.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst0, rst1;
  logic        fetch_en, stall_d, pcsrc_e;
  logic [31:0] pctarget_e;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        req0, req1, valid0, valid1;
  logic [31:0] addr0, addr1, instr0, instr1, pcd0, pcd1, pc4d0, pc4d1, wait0, wait1;

  fetch_ctrl #(.XLEN(32), .RESET_PC(RPC0)) u_dut0 (
    .clk(clk), .rst_n(rst0), .fetch_en(fetch_en), .StallD(stall_d),
    .PCSrcE(pcsrc_e), .PCTargetE(pctarget_e), .imem_req(req0),
    .imem_addr(addr0), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(instr0), .PCD(pcd0), .PCPlus4D(pc4d0), .ValidD(valid0),
    .wait_cycles(wait0)
  );

  fetch_ctrl #(.XLEN(32), .RESET_PC(RPC1)) u_dut1 (
    .clk(clk), .rst_n(rst1), .fetch_en(fetch_en), .StallD(stall_d),
    .PCSrcE(pcsrc_e), .PCTargetE(pctarget_e), .imem_req(req1),
    .imem_addr(addr1), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(instr1), .PCD(pcd1), .PCPlus4D(pc4d1), .ValidD(valid1),
    .wait_cycles(wait1)
  );

  // Observed instance.
  logic        sel;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_pcd, obs_pc4d, obs_wait;

  always_comb begin
    obs_req   = sel ? req1   : req0;
    obs_valid = sel ? valid1 : valid0;
    obs_addr  = sel ? addr1  : addr0;
    obs_instr = sel ? instr1 : instr0;
    obs_pcd   = sel ? pcd1   : pcd0;
    obs_pc4d  = sel ? pc4d1  : pc4d0;
    obs_wait  = sel ? wait1  : wait0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Memory responder state.
  logic        mem_pend;
  int          mem_cd;
  int          mem_lat;
  logic [31:0] mem_addr;
  logic        stale_rv;

  // Event logs taken from the observed instance.
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] dlv_log[$];
  int          cyc;

  function automatic logic [31:0] req_at(int i);
    return (req_log.size() > i) ? req_log[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] dlv_at(int i);
    return (dlv_log.size() > i) ? dlv_log[i] : 32'hDEAD_DEAD;
  endfunction

  // Reference model.
  logic [31:0] m_pc;
  logic        m_req;       // a request is on the bus this cycle
  logic        m_busy;      // a request has gone out and its response is pending
  logic        m_kill;      // the pending response must be dropped
  logic        m_skid;      // a response is parked behind a held IF/ID
  logic [31:0] m_skid_instr, m_skid_pc;
  logic        m_vd;
  logic [31:0] m_instr, m_pcd, m_pc4d, m_wait;

  task automatic model_reset(input logic [31:0] pc);
    m_pc = pc; m_req = 0; m_busy = 0; m_kill = 0; m_skid = 0;
    m_skid_instr = 0; m_skid_pc = 0;
    m_vd = 0; m_instr = 0; m_pcd = 0; m_pc4d = 0; m_wait = 0;
    req_log.delete(); req_cyc.delete(); dlv_log.delete(); cyc = 0;
  endtask

  task automatic model_update(input logic fen, input logic stall, input logic br,
                              input logic [31:0] tgt, input logic rv, input logic [31:0] rd);
    logic        deliver, next_req;
    logic [31:0] d_instr, d_pc;
    deliver = 0; next_req = 0; d_instr = 0; d_pc = 0;
    if (m_req) begin
      m_busy = 1;
      m_kill = br;
      if (br) m_pc = tgt;
    end else if (m_busy) begin
      if (!rv) begin
        if (m_wait != 32'hFFFF_FFFF) m_wait = m_wait + 1;
        if (br) begin m_kill = 1; m_pc = tgt; end
      end else begin
        m_busy = 0;
        if (br || m_kill) begin
          if (br) m_pc = tgt;
          m_kill = 0;
          next_req = 1;
        end else if (!m_vd || !stall) begin
          deliver = 1; d_instr = rd; d_pc = m_pc;
          m_pc = m_pc + 4;
          next_req = fen;
        end else begin
          m_skid = 1; m_skid_instr = rd; m_skid_pc = m_pc;
        end
      end
    end else if (m_skid) begin
      if (br) begin
        m_skid = 0; m_pc = tgt; next_req = 1;
      end else if (!stall) begin
        deliver = 1; d_instr = m_skid_instr; d_pc = m_skid_pc;
        m_skid = 0; m_pc = m_pc + 4; next_req = fen;
      end
    end else begin
      if (br) m_pc = tgt;
      next_req = fen;
    end
    m_req = next_req;
    if (br) m_vd = 0;
    else if (deliver) begin
      m_vd = 1; m_instr = d_instr; m_pcd = d_pc; m_pc4d = d_pc + 4;
    end else if (!stall) m_vd = 0;
  endtask

  // One cycle: sample and compare at the falling edge, then drive this
  // cycle's inputs and advance the model.
  task automatic step(input logic fen, input logic stall, input logic br, input logic [31:0] tgt);
    logic        rv;
    logic [31:0] rd;
    @(negedge clk);
    check("imem_req", 32'(obs_req), 32'(m_req));
    if (m_req) check("imem_addr", obs_addr, m_pc);
    check("ValidD", 32'(obs_valid), 32'(m_vd));
    check("InstrD", obs_instr, m_instr);
    check("PCD", obs_pcd, m_pcd);
    check("PCPlus4D", obs_pc4d, m_pc4d);
    check("wait_cycles", obs_wait, m_wait);
    if (obs_req) begin req_log.push_back(obs_addr); req_cyc.push_back(cyc); end
    if (obs_valid) dlv_log.push_back(obs_pcd);

    rv = 1'b0;
    rd = $urandom;
    if (mem_pend) begin
      mem_cd--;
      if (mem_cd == 0) begin
        rv = 1'b1; rd = mem_addr | 32'hA000_0000; mem_pend = 1'b0;
      end
    end
    if (stale_rv) begin rv = 1'b1; rd = 32'hDEAD_BEEF; end
    if (obs_req) begin mem_pend = 1'b1; mem_cd = mem_lat; mem_addr = obs_addr; end

    fetch_en = fen; stall_d = stall; pcsrc_e = br; pctarget_e = tgt;
    imem_rvalid = rv; imem_rdata = rd;
    model_update(fen, stall, br, tgt, rv, rd);
    cyc++;
  endtask

  task automatic run(input int n, input logic fen, input logic stall,
                     input logic br, input logic [31:0] tgt);
    for (int i = 0; i < n; i++) step(fen, stall, br, tgt);
  endtask

  task automatic do_reset(input logic which);
    sel = which;
    if (which) rst1 = 1'b0; else rst0 = 1'b0;
    mem_pend = 1'b0; stale_rv = 1'b0;
    fetch_en = 0; stall_d = 0; pcsrc_e = 0; pctarget_e = 0; imem_rvalid = 0; imem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    if (which) rst1 = 1'b1; else rst0 = 1'b1;
    model_reset(which ? RPC1 : RPC0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 0; rst1 = 0; sel = 0;
    fetch_en = 0; stall_d = 0; pcsrc_e = 0; pctarget_e = 0;
    imem_rvalid = 0; imem_rdata = 0;
    mem_pend = 0; mem_cd = 0; mem_lat = 1; mem_addr = 0; stale_rv = 0;
    model_reset(RPC0);

    // Reset values and steady 1-cycle-latency streaming.
    do_reset(0);
    check("rst_ValidD", 32'(obs_valid), 32'd0);
    check("rst_InstrD", obs_instr, 32'd0);
    check("rst_PCD", obs_pcd, 32'd0);
    check("rst_PCPlus4D", obs_pc4d, 32'd0);
    check("rst_wait", obs_wait, 32'd0);
    check("rst_req", 32'(obs_req), 32'd0);
    mem_lat = 1;
    run(8, 1, 0, 0, 0);
    check("A_req0", req_at(0), 32'h0);
    check("A_req1", req_at(1), 32'h4);
    check("A_req2", req_at(2), 32'h8);
    check("A_req_gap", 32'((req_cyc.size() > 1) ? req_cyc[1] - req_cyc[0] : 0), 32'd2);
    check("A_dlv0", dlv_at(0), 32'h0);
    check("A_dlv1", dlv_at(1), 32'h4);
    check("A_dlv2", dlv_at(2), 32'h8);
    check("A_pc4d", obs_pc4d, 32'd12);

    // Latency 3 on the first request.
    do_reset(0);
    mem_lat = 3;
    run(5, 1, 0, 0, 0);
    check("B_one_req", 32'(req_log.size()), 32'd1);
    mem_lat = 1;
    run(1, 1, 0, 0, 0);
    check("B_wait", obs_wait, 32'd2);
    check("B_valid", 32'(obs_valid), 32'd1);
    check("B_pcd", obs_pcd, 32'h0);
    check("B_instr", obs_instr, 32'hA000_0000);

    // Response for addr 8 arrives while IF/ID is held with PCD=4.
    do_reset(0);
    mem_lat = 1;
    run(5, 1, 0, 0, 0);
    run(4, 1, 1, 0, 0);
    check("C_hold_pcd", obs_pcd, 32'h4);
    check("C_hold_valid", 32'(obs_valid), 32'd1);
    check("C_hold_noreq", 32'(obs_req), 32'd0);
    check("C_req_count", 32'(req_log.size()), 32'd3);
    run(2, 1, 0, 0, 0);
    check("C_pcd", obs_pcd, 32'h8);
    check("C_valid", 32'(obs_valid), 32'd1);
    check("C_req", 32'(obs_req), 32'd1);
    check("C_addr", obs_addr, 32'hC);

    // Redirect during WAIT; the late response is dropped.
    do_reset(0);
    mem_lat = 1;
    run(3, 1, 0, 0, 0);
    mem_lat = 3;
    run(1, 1, 0, 0, 0);
    run(1, 1, 0, 1, 32'h100);
    mem_lat = 1;
    run(1, 1, 0, 0, 0);
    check("D_flush_valid", 32'(obs_valid), 32'd0);
    run(2, 1, 0, 0, 0);
    check("D_req", 32'(obs_req), 32'd1);
    check("D_addr", obs_addr, 32'h100);
    run(2, 1, 0, 0, 0);
    check("D_valid", 32'(obs_valid), 32'd1);
    check("D_pcd", obs_pcd, 32'h100);
    check("D_instr", obs_instr, 32'hA000_0100);
    check("D_dlv_count", 32'(dlv_log.size()), 32'd2);

    // Redirect and stall together while the skid is full.
    do_reset(0);
    mem_lat = 1;
    run(5, 1, 0, 0, 0);
    run(3, 1, 1, 0, 0);
    run(1, 1, 1, 1, 32'h200);
    run(1, 1, 0, 0, 0);
    check("E_valid", 32'(obs_valid), 32'd0);
    check("E_req", 32'(obs_req), 32'd1);
    check("E_addr", obs_addr, 32'h200);
    run(2, 1, 0, 0, 0);
    check("E_valid2", 32'(obs_valid), 32'd1);
    check("E_pcd", obs_pcd, 32'h200);

    // PC wrap, reset in WAIT, stale responses after release.
    do_reset(1);
    mem_lat = 1;
    run(3, 1, 0, 0, 0);
    mem_lat = 3;
    run(1, 1, 0, 0, 0);
    check("F_pcd", obs_pcd, 32'hFFFF_FFFC);
    check("F_pc4d", obs_pc4d, 32'h0);
    check("F_req", 32'(obs_req), 32'd1);
    check("F_addr_wrap", obs_addr, 32'h0);
    run(2, 1, 0, 0, 0);
    #2 rst1 = 1'b0;
    #1;
    check("F_rst_valid", 32'(obs_valid), 32'd0);
    check("F_rst_instr", obs_instr, 32'd0);
    check("F_rst_pcd", obs_pcd, 32'd0);
    check("F_rst_pc4d", obs_pc4d, 32'd0);
    check("F_rst_wait", obs_wait, 32'd0);
    check("F_rst_req", 32'(obs_req), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b1;
    model_reset(RPC1);
    mem_lat = 1;
    run(1, 1, 0, 0, 0);
    stale_rv = 1'b1;
    run(1, 1, 0, 0, 0);
    stale_rv = 1'b0;
    run(2, 1, 0, 0, 0);
    check("F_first_req", req_at(0), 32'hFFFF_FFFC);
    check("F_valid", 32'(obs_valid), 32'd1);
    check("F_pcd2", obs_pcd, 32'hFFFF_FFFC);
    check("F_instr", obs_instr, 32'hFFFF_FFFC);

    // Randomized traffic against the model.
    do_reset(0);
    for (int i = 0; i < 3000; i++) begin
      logic        fen, stall, br;
      logic [31:0] tgt;
      fen     = ($urandom_range(0, 9) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      br      = ($urandom_range(0, 15) == 0);
      tgt     = $urandom & 32'hFFFF_FFFC;
      mem_lat = $urandom_range(1, 4);
      step(fen, stall, br, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the pipeline fetch stage.
- Owns the PC register and a single-outstanding request/response handshake to a variable-latency instruction memory.
- Owns the IF/ID pipeline register.
- Applies decode stalls, execute-stage branch/jump redirects (flush), and a one-entry skid buffer. Counts memory-wait cycles for performance analysis.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/instruction width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  1 = fetching permitted; 0 = no new requests issued
- StallD  in  1  decode stalled; IF/ID must hold
- PCSrcE  in  1  redirect/flush request from execute
- PCTargetE  in  XLEN  redirect target
- imem_req  out  1  one-cycle request pulse
- imem_addr  out  XLEN  request address, valid when imem_req=1
- imem_rvalid  in  1  response valid; earliest 1 cycle after imem_req
- imem_rdata  in  XLEN  response instruction
- InstrD  out  XLEN  IF/ID instruction
- PCD  out  XLEN  IF/ID PC
- PCPlus4D  out  XLEN  IF/ID PC+4
- ValidD  out  1  IF/ID holds a live instruction
- wait_cycles  out  32  saturating count of cycles spent waiting on memory

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc_q=RESET_PC.
  - InstrD, PCD, PCPlus4D, wait_cycles, skid buffer = 0; ValidD=0; imem_req=0.
  - Reset mid-transaction abandons the outstanding request; a stale imem_rvalid after reset release is ignored in IDLE/ISSUE.
- imem_addr = pc_q at all times; only meaningful while imem_req=1.
- Arithmetic: PC+4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0, no flag.
- At most one request outstanding. Throughput is 1 instruction per 2 cycles with 1-cycle memory latency.
- States:
  - IDLE: imem_req=0. fetch_en=1 -> ISSUE.
  - ISSUE: imem_req=1 for exactly this cycle -> WAIT. PCSrcE=1 in ISSUE: request still issued, pc_q<=PCTargetE -> DISCARD.
  - WAIT:
    - PCSrcE=1: pc_q<=PCTargetE. If imem_rvalid also =1, drop response -> ISSUE; else -> DISCARD.
    - imem_rvalid=1 and IF/ID free (ValidD=0 or StallD=0): load InstrD=imem_rdata, PCD=pc_q, PCPlus4D=pc_q+4, ValidD=1; pc_q<=pc_q+4; -> ISSUE if fetch_en else IDLE.
    - imem_rvalid=1 and IF/ID held (ValidD=1 and StallD=1): capture data+pc_q in skid buffer -> HOLD.
  - HOLD:
    - PCSrcE=1: discard skid, pc_q<=PCTargetE -> ISSUE.
    - StallD=0: move skid into IF/ID (ValidD=1), pc_q<=pc_q+4 -> ISSUE/IDLE per fetch_en.
  - DISCARD: waiting for the killed response.
    - imem_rvalid=1: drop it -> ISSUE.
    - PCSrcE=1 again: pc_q<=PCTargetE, stay. Both in the same cycle: take new target, drop response -> ISSUE.
- IF/ID register updates, in priority order:
  - PCSrcE=1 -> ValidD<=0 (flush); data fields hold.
  - Else load per WAIT/HOLD rules.
  - Else StallD=1 -> hold.
  - Else ValidD<=0 (bubble).
- Flush beats stall when PCSrcE and StallD coincide.
- fetch_en deassert never cancels an outstanding request; its response is delivered normally, then -> IDLE.
- wait_cycles increments every cycle in WAIT or DISCARD with imem_rvalid=0; saturates at 32'hFFFF_FFFF.

Test Plan:
- Reset, fetch_en=1, memory latency 1, rdata=addr|32'hA000_0000 -> imem_req at addr 0,4,8 on alternate cycles; ValidD pulses with PCD=0,4,8 and PCPlus4D=4,8,12.
- Latency 3 at addr 0 -> wait_cycles=2 after first response; InstrD loaded the cycle after rvalid; no second imem_req before rvalid.
- StallD=1 with ValidD=1 (PCD=4) when response for addr 8 arrives -> IF/ID keeps PCD=4 and no new request is issued. On StallD=0, PCD=8 and imem_req at addr 12 next cycle.
- PCSrcE=1, PCTargetE=32'h100 during WAIT (rvalid 2 cycles later) -> ValidD=0, late response dropped, next imem_req addr=32'h100, next ValidD with PCD=32'h100.
- PCSrcE=1 and StallD=1 in the same cycle, with the HOLD skid full -> ValidD=0, skid dropped, next request addr=PCTargetE.
- RESET_PC=32'hFFFF_FFFC -> first request at FFFF_FFFC, PCPlus4D=0, next request at 0. Assert rst_n=0 while in WAIT -> all outputs 0 immediately. After release, a stale rvalid is ignored and the first request is at RESET_PC.
